hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB, 3-bit register addresses, 5-bit opcodes).
- Detects data hazards that the forwarding unit cannot cover and stalls IF/ID, inserting bubbles into ID/EX.
- Squashes wrong-path instructions on taken branches: ber/bner/jr resolve in ID, be/bne/j resolve in MEM.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- BR_LOAD_STALL, 2, stall cycles when an ID-resolved branch depends on a load in ID/EX (legal 1..3).
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IFID_OPCODE  in  5  opcode of the instruction in ID.
- IFID_RD_ADDR  in  3  RD field in ID.
- IFID_R1_ADDR  in  3  R1 field in ID.
- IFID_R2_ADDR  in  3  R2 field in ID.
- IDEX_OPCODE  in  5  opcode in EX.
- IDEX_RD_ADDR  in  3  destination register in EX.
- BRANCH_TAKEN_ID  in  1  ber/bner/jr in ID resolved taken.
- BRANCH_TAKEN_MEM  in  1  be/bne/j in MEM resolved taken.
- CNT_CLR  in  1  synchronous clear of both counters.
- PC_WRITE  out  1  PC update enable.
- IFID_WRITE  out  1  IF/ID register load enable.
- IDEX_BUBBLE  out  1  load NOP (opcode 5'h1f) into ID/EX.
- IFID_FLUSH  out  1  replace IF/ID contents with NOP.
- IDEX_FLUSH  out  1  replace ID/EX contents with NOP.
- EXMEM_FLUSH  out  1  replace EX/MEM contents with NOP.
- STALLED  out  1  high when the FSM state is STALL.
- STALL_CYCLES  out  CNT_W  saturating count of stalled cycles.
- FLUSH_EVENTS  out  CNT_W  saturating count of flush events (ID and MEM).

Behaviour:
- Opcodes:
  - bne=10011, be=10100, bner=10101, ber=10110, j=10111, jr=11000, li=11001, load=11010, store=11011, NOP=11111.
  - All other values are ALU ops.
- Source usage by the ID instruction:
  - ALU and load use R1, R2.
  - store uses R1, R2, RD.
  - ber/bner use RD, R2.
  - jr uses R2.
  - j/be/bne/li/NOP use no sources.
- Load-use hazard (LU): IDEX_OPCODE==load, and IDEX_RD_ADDR equals a used source of a non-branch ID instruction. Requires 1 stall cycle.
- Branch-load hazard (BL): IDEX_OPCODE==load, ID op in {ber, bner, jr}, and IDEX_RD_ADDR equals a used source. Requires BR_LOAD_STALL cycles.
- FSM states: RUN, STALL. A 2-bit counter cnt holds the remaining stall cycles.
  - RUN, LU, or BL with BR_LOAD_STALL==1: stall this cycle combinationally; stay in RUN.
  - RUN, BL with BR_LOAD_STALL>1: stall this cycle; next state STALL, cnt=BR_LOAD_STALL-1.
  - STALL: stall every cycle; cnt decrements; when cnt==1, next state RUN. Hazard detection is masked in STALL.
- Stall outputs: PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1. When not stalling: PC_WRITE=1, IFID_WRITE=1, IDEX_BUBBLE=0.
- ID flush: BRANCH_TAKEN_ID while not stalling drives IFID_FLUSH=1 for that cycle. While stalling, BRANCH_TAKEN_ID is ignored.
- MEM flush: BRANCH_TAKEN_MEM drives IFID_FLUSH=IDEX_FLUSH=EXMEM_FLUSH=1 and PC_WRITE=1.
  - Overrides any stall in the same cycle.
  - Aborts STALL: next state RUN, cnt=0.
  - IDEX_BUBBLE=0 that cycle.
- Priority: MEM flush > stall > ID flush. Hazards and ID flush that coincide with a MEM flush are discarded.
- All flush, stall and write outputs are combinational from the inputs and registered state. There is no added latency.
- Counters:
  - STALL_CYCLES increments each cycle the stall outputs are asserted.
  - FLUSH_EVENTS increments on each cycle with IFID_FLUSH=1.
  - Both saturate at all-ones.
  - CNT_CLR has priority over increment.
- Reset values: state=RUN, cnt=0, counters=0, STALLED=0. Combinational outputs then evaluate as RUN: PC_WRITE=1, IFID_WRITE=1, all flush and bubble outputs 0 unless hazard inputs are active.
- Reset asserted mid-stall returns to RUN immediately (asynchronous). No stall cycles are carried over.

Test Plan:
- IDEX=load rd=3, ID=add r1=3 r2=5 -> exactly 1 cycle with PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1; STALL_CYCLES=1; STALLED stays 0.
- IDEX=load rd=2, ID=ber rd=2, BR_LOAD_STALL=2 -> 2 stall cycles; STALLED=1 on the second; back to RUN on the third.
- Stall in progress (cycle 2 of 3, BR_LOAD_STALL=3) and BRANCH_TAKEN_MEM=1 -> all three flushes=1, PC_WRITE=1, IDEX_BUBBLE=0; next cycle RUN, no further stall.
- BRANCH_TAKEN_ID=1 in RUN with no hazard -> IFID_FLUSH=1 only; FLUSH_EVENTS increments by 1. Repeated during a stall -> ignored.
- IDEX=store rd=3, ID=add r1=3; also IDEX=load rd=4 with ID=j -> no stall in either case.
- Preload STALL_CYCLES to 16'hFFFF and stall -> stays at FFFF. CNT_CLR=1 during a stall -> 0. RST pulse mid-STALL -> STALLED=0 and PC_WRITE=1 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Stalls IF/ID and bubbles ID/EX on load hazards that forwarding cannot
// cover, squashes wrong-path instructions on taken branches, and keeps
// saturating stall/flush debug counters.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   IFID_OPCODE/_*_ADDR instruction currently in ID (opcode, RD, R1, R2)
//   IDEX_OPCODE/_RD     instruction currently in EX (opcode, destination)
//   BRANCH_TAKEN_ID     ber/bner/jr in ID resolved taken
//   BRANCH_TAKEN_MEM    be/bne/j in MEM resolved taken
//   CNT_CLR             synchronous clear of both counters
//   PC_WRITE, IFID_WRITE, IDEX_BUBBLE  stall controls (combinational)
//   IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH squash controls (combinational)
//   STALLED             FSM is in the multi-cycle STALL state
//   STALL_CYCLES, FLUSH_EVENTS         saturating debug counters
module hazard_ctrl #(
    parameter int unsigned BR_LOAD_STALL = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       IFID_OPCODE,
    input  logic [2:0]       IFID_RD_ADDR,
    input  logic [2:0]       IFID_R1_ADDR,
    input  logic [2:0]       IFID_R2_ADDR,
    input  logic [4:0]       IDEX_OPCODE,
    input  logic [2:0]       IDEX_RD_ADDR,
    input  logic             BRANCH_TAKEN_ID,
    input  logic             BRANCH_TAKEN_MEM,
    input  logic             CNT_CLR,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IDEX_BUBBLE,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_FLUSH,
    output logic             STALLED,
    output logic [CNT_W-1:0] STALL_CYCLES,
    output logic [CNT_W-1:0] FLUSH_EVENTS
);

    localparam logic [4:0] OP_BNE   = 5'b10011;
    localparam logic [4:0] OP_BE    = 5'b10100;
    localparam logic [4:0] OP_BNER  = 5'b10101;
    localparam logic [4:0] OP_BER   = 5'b10110;
    localparam logic [4:0] OP_J     = 5'b10111;
    localparam logic [4:0] OP_JR    = 5'b11000;
    localparam logic [4:0] OP_LI    = 5'b11001;
    localparam logic [4:0] OP_LOAD  = 5'b11010;
    localparam logic [4:0] OP_STORE = 5'b11011;
    localparam logic [4:0] OP_NOP   = 5'b11111;

    // Remaining STALL-state cycles after the first (RUN-state) stall cycle.
    localparam logic [1:0] CNT_LD = 2'(BR_LOAD_STALL - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic use_r1, use_r2, use_rd, id_branch;
    logic src_match, lu_hazard, bl_hazard;
    logic stall_c;

    // Source-register usage of the instruction in ID.
    always_comb begin
        use_r1    = 1'b0;
        use_r2    = 1'b0;
        use_rd    = 1'b0;
        id_branch = 1'b0;
        case (IFID_OPCODE)
            OP_BNE, OP_BE, OP_J, OP_LI, OP_NOP: ;
            OP_BER, OP_BNER: begin
                use_rd    = 1'b1;
                use_r2    = 1'b1;
                id_branch = 1'b1;
            end
            OP_JR: begin
                use_r2    = 1'b1;
                id_branch = 1'b1;
            end
            OP_STORE: begin
                use_r1 = 1'b1;
                use_r2 = 1'b1;
                use_rd = 1'b1;
            end
            default: begin
                // ALU ops and load
                use_r1 = 1'b1;
                use_r2 = 1'b1;
            end
        endcase
    end

    assign src_match = (use_r1 && (IFID_R1_ADDR == IDEX_RD_ADDR))
                    || (use_r2 && (IFID_R2_ADDR == IDEX_RD_ADDR))
                    || (use_rd && (IFID_RD_ADDR == IDEX_RD_ADDR));

    assign lu_hazard = (IDEX_OPCODE == OP_LOAD) && src_match && !id_branch;
    assign bl_hazard = (IDEX_OPCODE == OP_LOAD) && src_match &&  id_branch;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and pipeline controls; MEM flush > stall > ID flush.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_c     = 1'b0;
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IDEX_BUBBLE = 1'b0;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;

        case (state_q)
            ST_RUN: begin
                stall_c = lu_hazard || bl_hazard;
                if (bl_hazard && (BR_LOAD_STALL > 1)) begin
                    state_d = ST_STALL;
                    cnt_d   = CNT_LD;
                end
            end
            ST_STALL: begin
                // Hazard detection is masked while draining the stall.
                stall_c = 1'b1;
                cnt_d   = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase

        if (BRANCH_TAKEN_MEM) begin
            // Squash everything younger than MEM and abort any stall.
            state_d     = ST_RUN;
            cnt_d       = 2'd0;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
        end else if (stall_c) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_BUBBLE = 1'b1;
        end else if (BRANCH_TAKEN_ID) begin
            IFID_FLUSH = 1'b1;
        end
    end

    assign STALLED = (state_q == ST_STALL);

    // Saturating debug counters; clear wins over increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CYCLES <= '0;
            FLUSH_EVENTS <= '0;
        end else if (CNT_CLR) begin
            STALL_CYCLES <= '0;
            FLUSH_EVENTS <= '0;
        end else begin
            if (IDEX_BUBBLE && (STALL_CYCLES != '1)) begin
                STALL_CYCLES <= STALL_CYCLES + CNT_W'(1);
            end
            if (IFID_FLUSH && (FLUSH_EVENTS != '1)) begin
                FLUSH_EVENTS <= FLUSH_EVENTS + CNT_W'(1);
            end
        end
    end

endmodule
